// File: rtl/dmux_stream_pkg.sv
// Shared constants and pointer-compare helpers for the stream demultiplexer.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package dmux_stream_pkg;

    localparam int                    DROP_CNT_W   = 8;
    localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = 8'd255;

    // Pointers carry one extra wrap bit above the address bits (bit aw).
    // Full when the wrap bits differ and the address bits match.
    function automatic logic ptr_full(input logic [31:0] wr_ptr,
                                      input logic [31:0] rd_ptr,
                                      input logic [4:0]  aw);
        logic [31:0] diff;
        logic [31:0] lsb_mask;
        diff     = wr_ptr ^ rd_ptr;
        lsb_mask = (32'd1 << aw) - 32'd1;
        return diff[aw] && ((diff & lsb_mask) == 32'd0);
    endfunction

    // Empty when both pointers, wrap bit included, are identical.
    function automatic logic ptr_empty(input logic [31:0] wr_ptr,
                                       input logic [31:0] rd_ptr);
        return wr_ptr == rd_ptr;
    endfunction

endpackage

// File: rtl/dmux_chan_fifo.sv
// Per-channel synchronous FIFO with a wrap-bit pointer scheme.
// Latency: a word pushed at edge t is visible on pop_data from cycle t+1.
// Backpressure: a push is ignored while full, and a pop is ignored while empty.
module dmux_chan_fifo
    import dmux_stream_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = ptr_full(32'(wr_ptr), 32'(rd_ptr), 5'(AW));
    assign empty    = ptr_empty(32'(wr_ptr), 32'(rd_ptr));
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    // Pointer update; the wrap bit takes care of itself by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is cleared on reset, so an idle channel presents zero data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/dmux_stream.sv
// 1-to-N stream demux (unicast by in_sel, or broadcast) with one FIFO per channel.
// Latency: a word accepted at edge t appears at its channel head from cycle t+1, and it is fully registered.
// Backpressure: in_ready depends only on the full flags (never on out_ready), and out-of-range selects are always accepted and dropped.
module dmux_stream
    import dmux_stream_pkg::*;
#(
    parameter  int N     = 4,
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int SEL_W = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    input  logic [SEL_W-1:0]      in_sel,
    input  logic                  in_bcast,
    output logic [N-1:0]          out_valid,
    input  logic [N-1:0]          out_ready,
    output logic [N*WIDTH-1:0]    out_data,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    logic [N-1:0] full;
    logic [N-1:0] empty;
    logic [N-1:0] sel_onehot;
    logic [N-1:0] push_vec;
    logic         sel_in_range;
    logic         accept;
    logic         drop;

    // Decode the target channel; an out-of-range select yields no one-hot bit.
    always_comb begin
        sel_onehot   = '0;
        sel_in_range = ({1'b0, in_sel} < (SEL_W+1)'(N));
        for (int k = 0; k < N; k++) begin
            sel_onehot[k] = (in_sel == SEL_W'(k));
        end
    end

    // Acceptance is decided from registered full flags only, and it is held low during reset.
    always_comb begin
        in_ready = 1'b0;
        if (!rst_n) begin
            in_ready = 1'b0;
        end else if (in_bcast) begin
            in_ready = ~(|full);
        end else if (!sel_in_range) begin
            in_ready = 1'b1;
        end else begin
            in_ready = ~(|(full & sel_onehot));
        end
    end

    assign accept   = in_valid & in_ready;
    assign drop     = accept & ~in_bcast & ~sel_in_range;
    assign push_vec = !accept ? '0 : (in_bcast ? '1 : sel_onehot);

    // Saturating count of words discarded for an out-of-range select.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (drop && drop_cnt != DROP_CNT_MAX) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_chan
        dmux_chan_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (push_vec[k]),
            .push_data (in_data),
            .pop       (out_ready[k] & ~empty[k]),
            .pop_data  (out_data[k*WIDTH +: WIDTH]),
            .full      (full[k]),
            .empty     (empty[k])
        );
        assign out_valid[k] = ~empty[k];
    end

endmodule
